ft_restore_ctrl: RTL and testbench
==================================

# ft_restore_ctrl

Checkpoint-restore controller sitting directly downstream of the fault-tolerant checkpoint memory (`ft_memory`). On a recovery request it reads back the saved architectural state over the memory's req/gnt/rvalid read port, one word at a time. It writes registers x1..x31 into the core register file, then reloads the PC. The core is held halted for the whole sequence.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0: byte address of checkpoint slot 0.
- `PC_SLOT`, default 32: word index of the saved PC. Registers occupy word indices 1..31 and x0 is never read.
- `MAX_WAIT`, default 255: maximum cycles spent in REQ or WAIT for one word before aborting. Must be ≥1.

Ports (clock and reset first):
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin restore. Sampled only in IDLE.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `halt_o` out 1: core halt request; equal to `busy_o`.
- `done_o` out 1: one-cycle pulse on successful completion.
- `fail_o` out 1: one-cycle pulse on error or timeout.
- `req_o` out 1: read request to checkpoint memory.
- `gnt_i` in 1: request accepted.
- `addr_o` out 32: byte address, `BASE_ADDR + 4*idx`.
- `rvalid_i` in 1: read data valid.
- `rdata_i` in 32: read data.
- `err_i` in 1: read error, qualified by `rvalid_i`.
- `rf_we_o` out 1: register-file write enable.
- `rf_waddr_o` out 5: register-file write address.
- `rf_wdata_o` out 32: register-file write data.
- `pc_set_o` out 1: one-cycle pulse that loads `pc_o` into the core.
- `pc_o` out 32: restored PC.

## Operation
States and transitions:
- **IDLE → REQ** on `start_i`; `idx` := 1.
- **REQ**: `req_o` = 1 and `addr_o` is stable.
  - `gnt_i` → WAIT.
  - Timeout → FAIL.
- **WAIT**: `req_o` = 0.
  - `rvalid_i & err_i` → FAIL.
  - `rvalid_i & !err_i & idx < 31` → REQ, with `idx`+1. Register write issued.
  - `rvalid_i & !err_i & idx == 31` → REQ, with `idx` := `PC_SLOT`. Register write issued.
  - `rvalid_i & !err_i & idx == PC_SLOT` → DONE. PC captured.
  - Timeout → FAIL.
- **DONE**: `done_o` = 1 and `pc_set_o` = 1 for one cycle, then → IDLE.
- **FAIL**: `fail_o` = 1 for one cycle, then → IDLE. No `pc_set_o` is issued; register writes already made stand.

Rules:
- Only one transaction is outstanding at a time.
- `rvalid_i` is sampled only in WAIT. In any other state it is ignored.
- `start_i` while busy is ignored.
- Timeout counter clears on every entry to REQ and WAIT. It fires when the count reaches `MAX_WAIT`.
- On a timeout in WAIT the transaction is abandoned. A late `rvalid_i` then arrives in IDLE and is ignored.
- `rf_waddr_o` = `idx[4:0]`. `rf_wdata_o` = `rdata_i` captured on the accepting `rvalid_i`.

## Timing
- All outputs are registered except `req_o`, `addr_o`, `busy_o` and `halt_o`, which are decoded from state and `idx`.
- Reset values: state IDLE, `idx` 0, `req_o` 0, `addr_o` `BASE_ADDR`, `busy_o` 0, `halt_o` 0, `done_o` 0, `fail_o` 0, `rf_we_o` 0, `rf_waddr_o` 0, `rf_wdata_o` 0, `pc_set_o` 0, `pc_o` 0.
- Reset mid-restore returns immediately to IDLE with all of the above values. No partial pulse is emitted.
- `start_i` sampled in cycle 0 → `req_o` high in cycle 1.
- `gnt_i` in the same cycle as `req_o` is accepted that cycle. `req_o` is low the following cycle.
- Register write timing: `rf_we_o` is high exactly in the cycle after the accepting `rvalid_i`. That same cycle is the next REQ cycle.
- With zero-wait `gnt_i` and `rvalid_i` one cycle later, each word takes 2 cycles.
  - Word k (k = 1..32, where k = 32 is the PC) is requested in cycle 2k−1 and returns in cycle 2k.
  - DONE occurs in cycle 65.

## Structure
- Shared package `ft_pkg` holds:
  - `restore_state_e` (IDLE, REQ, WAIT, DONE, FAIL);
  - `NUM_GPR` = 32;
  - `CKPT_PC_SLOT` = 32, used as the default for `PC_SLOT`.
- One sub-module: `ft_restore_timer`, a `$clog2(MAX_WAIT+1)`-bit counter with clear and enable inputs and an `expired_o` output.

## Test plan
- Memory model preloaded with `mem[i]` = 32'h1111_1100+i; `gnt_i` immediate, `rvalid_i` one cycle later; start in cycle 0.
  - Expect 31 writes: x1 = 32'h1111_1101 … x31 = 32'h1111_111F.
  - Expect `pc_o` = 32'h1111_1120, with `pc_set_o` and `done_o` in cycle 65.
- Same memory with `gnt_i` delayed 3 cycles per request → `addr_o` and `req_o` held stable while waiting; data and order identical; `done_o` in cycle 161.
- `err_i` with `rvalid_i` on word 7 → x1..x6 written, no x7 write, `fail_o` pulse, no `pc_set_o`, back to IDLE.
- `MAX_WAIT` = 4 and `rvalid_i` never returned for word 1 → `fail_o` 4 cycles after entering WAIT; a later `rvalid_i` in IDLE causes no write.
- `rst_ni` asserted during word 10 → all outputs return to their reset values immediately; a new `start_i` restarts from x1.
- `start_i` pulsed repeatedly mid-restore → ignored; exactly 31 writes and one `done_o`.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types and constants for the fault-tolerant checkpoint/restore blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft_pkg;

  // Restore sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    FAIL
  } restore_state_e;

  // Architectural register count, including x0.
  localparam int NUM_GPR      = 32;
  // Highest register index that gets restored.
  localparam int LAST_GPR     = NUM_GPR - 1;
  // Word slot that holds the saved PC in a checkpoint image.
  localparam int CKPT_PC_SLOT = 32;

endpackage

// File: rtl/ft_restore_timer.sv
// Per-word watchdog for the restore sequencer: counts cycles spent waiting on memory.
// Latency: expired_o is combinational from the count; it asserts in the MAX_WAIT-th enabled cycle.
// Backpressure: none; clr_i wins over en_i and the count saturates at MAX_WAIT.
module ft_restore_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles since the last clear, saturating so it never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CW'(MAX_WAIT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The count starts at zero in the first waiting cycle, so MAX_WAIT-1 marks the
  // last cycle the sequencer is allowed to spend on one word.
  assign expired_o = en_i && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/ft_restore_ctrl.sv
// Restores x1..x31 and the PC from checkpoint memory, holding the core halted throughout.
// Latency: start to first req_o is 1 cycle; each word costs >=2 cycles (req/gnt then rvalid).
// Backpressure: one read outstanding; req_o/addr_o held until gnt_i, watchdog aborts stalls.
module ft_restore_ctrl
  import ft_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          PC_SLOT   = CKPT_PC_SLOT,
  parameter int          MAX_WAIT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        halt_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        pc_set_o,
  output logic [31:0] pc_o
);

  restore_state_e state_q, state_d;
  logic [31:0]    idx_q, idx_d;
  // Set once the register words are finished and the PC word is in flight, so the
  // PC slot is recognised even if PC_SLOT were placed inside the register range.
  logic           pc_phase_q, pc_phase_d;

  logic           wr_d;
  logic           pc_cap_d;
  logic           fail_d;

  logic           tmr_clr;
  logic           tmr_en;
  logic           tmr_expired;

  ft_restore_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Restart the watchdog on every state change so REQ and WAIT each get a full budget.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == REQ) || (state_q == WAIT);

  // State, word index and PC-phase registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pc_phase_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pc_phase_q <= pc_phase_d;
    end
  end

  // Next-state and per-word strobes; a handshake in the same cycle as expiry wins.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pc_phase_d = pc_phase_q;
    wr_d       = 1'b0;
    pc_cap_d   = 1'b0;
    fail_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = REQ;
          idx_d      = 32'd1;
          pc_phase_d = 1'b0;
        end
      end
      REQ: begin
        if (gnt_i) begin
          state_d = WAIT;
        end else if (tmr_expired) begin
          state_d = FAIL;
          fail_d  = 1'b1;
        end
      end
      WAIT: begin
        if (rvalid_i) begin
          if (err_i) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else if (pc_phase_q) begin
            state_d  = DONE;
            pc_cap_d = 1'b1;
          end else begin
            state_d = REQ;
            wr_d    = 1'b1;
            if (idx_q < 32'(LAST_GPR)) begin
              idx_d = idx_q + 32'd1;
            end else begin
              idx_d      = 32'(PC_SLOT);
              pc_phase_d = 1'b1;
            end
          end
        end else if (tmr_expired) begin
          state_d = FAIL;
          fail_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: pulses line up with the DONE/FAIL state, writes with the next REQ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_o     <= 1'b0;
      fail_o     <= 1'b0;
      pc_set_o   <= 1'b0;
      pc_o       <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      done_o   <= pc_cap_d;
      pc_set_o <= pc_cap_d;
      fail_o   <= fail_d;
      rf_we_o  <= wr_d;
      if (pc_cap_d) begin
        pc_o <= rdata_i;
      end
      if (wr_d) begin
        rf_waddr_o <= idx_q[4:0];
        rf_wdata_o <= rdata_i;
      end
    end
  end

  // Decoded outputs: request and address follow the current word directly.
  assign busy_o = (state_q != IDLE);
  assign halt_o = busy_o;
  assign req_o  = (state_q == REQ);
  assign addr_o = BASE_ADDR + (idx_q << 2);

endmodule

// File: tb/tb_ft_restore_ctrl.sv
// Bench for ft_restore_ctrl: randomised memory responder plus a restore-level reference model.
// Latency: expected events come from the checkpoint contents; cycle timing checked for fixed-delay runs.
// Backpressure: responder inserts grant and read-data delays within the watchdog budget.
module tb_ft_restore_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          MW   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic        err = 1'b0;
  logic [31:0] rdata = '0;
  logic        busy, halt, done, fail, req, rf_we, pc_set;
  logic [31:0] addr, rf_wdata, pc;
  logic [4:0]  rf_waddr;

  ft_restore_ctrl #(
    .BASE_ADDR (BASE),
    .MAX_WAIT  (MW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .busy_o     (busy),
    .halt_o     (halt),
    .done_o     (done),
    .fail_o     (fail),
    .req_o      (req),
    .gnt_i      (gnt),
    .addr_o     (addr),
    .rvalid_i   (rvalid),
    .rdata_i    (rdata),
    .err_i      (err),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata),
    .pc_set_o   (pc_set),
    .pc_o       (pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          kind;   // 0 register write, 1 done with PC, 2 fail
    logic [4:0]  a;
    logic [31:0] d;
  } ev_t;
  ev_t exp_q[$];

  logic [31:0] mem [0:63];
  int cfg_gd   = 0;   // grant delay in cycles, -1 random 0..3
  int cfg_rl   = 1;   // rvalid latency after grant, -1 random 1..4
  int cfg_err  = -1;  // word returning err_i
  int cfg_drop = -1;  // word whose rvalid comes back only after the watchdog

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 64; i++) mem[i] = rnd ? $urandom : (32'h1111_1100 + 32'(i));
  endtask

  // A restore copies words 1..31 into x1..x31 until the first bad word, then
  // either loads word 32 as the PC or reports failure.
  task automatic build_expect();
    int  stop;
    ev_t e;
    exp_q.delete();
    stop = 33;
    if (cfg_err  >= 1 && cfg_err  <= 32) stop = cfg_err;
    if (cfg_drop >= 1 && cfg_drop <= 32 && cfg_drop < stop) stop = cfg_drop;
    for (int w = 1; w <= 31; w++) begin
      if (w < stop) begin
        e.kind = 0; e.a = 5'(w); e.d = mem[w];
        exp_q.push_back(e);
      end
    end
    e.a = '0;
    if (stop <= 32) begin
      e.kind = 2; e.d = '0;
    end else begin
      e.kind = 1; e.d = mem[32];
    end
    exp_q.push_back(e);
  endtask

  // ---------------- memory responder ----------------
  int          ph = 0, rcnt = 0, tgt = 0, word = 0;
  logic [31:0] held_addr = '0;

  initial forever begin
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    if (!rst_n) begin
      ph = 0; rcnt = 0;
    end else if (ph == 0) begin
      if (req) begin
        if (rcnt == 0) begin
          held_addr = addr;
          tgt = (cfg_gd < 0) ? int'($urandom_range(0, 3)) : cfg_gd;
        end else begin
          chk("addr_stable", addr, held_addr);
        end
        if (rcnt == tgt) begin
          gnt  = 1'b1;
          word = int'((addr - BASE) >> 2);
          ph   = 1; rcnt = 0;
          tgt  = (cfg_rl < 0) ? int'($urandom_range(1, 4)) : cfg_rl;
        end else begin
          rcnt++;
        end
      end else if (rcnt != 0) begin
        chk("req_held", 32'(req), 32'd1);
        rcnt = 0;
      end
    end else begin
      rcnt++;
      if (word == cfg_drop) begin
        if (rcnt == 8) begin
          rvalid = 1'b1; rdata = mem[word & 63]; ph = 0; rcnt = 0;
        end
      end else if (rcnt == tgt) begin
        rvalid = 1'b1; rdata = mem[word & 63]; err = (word == cfg_err);
        ph = 0; rcnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int wr_cnt = 0, done_cnt = 0, fail_cnt = 0, last_ev_cyc = 0;

  task automatic take(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event actual_kind=%0d required=none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind == 0) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
        chk("rf_wdata", rf_wdata, e.d);
      end else if (kind == 1) begin
        chk("done_with_pc_set", {30'd0, done, pc_set}, 32'd3);
        chk("pc_value", pc, e.d);
      end else begin
        chk("fail_without_pc_set", 32'(pc_set), 32'd0);
      end
    end
    chk("halt_eq_busy", 32'(halt), 32'(busy));
    last_ev_cyc = cyc;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rf_we) begin take(0); wr_cnt++; end
      if (done || pc_set) begin take(1); done_cnt++; end
      if (fail) begin take(2); fail_cnt++; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_halt"},     32'(halt),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_fail"},     32'(fail),     32'd0);
    chk({tag, "_req"},      32'(req),      32'd0);
    chk({tag, "_addr"},     addr,          BASE);
    chk({tag, "_rf_we"},    32'(rf_we),    32'd0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, "_rf_wdata"}, rf_wdata,      32'd0);
    chk({tag, "_pc_set"},   32'(pc_set),   32'd0);
    chk({tag, "_pc"},       pc,            32'd0);
  endtask

  task automatic run(input string name, input int exp_end, input bit spam);
    int  base, t0;
    bit  finished;
    base = done_cnt + fail_cnt;
    build_expect();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    finished = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done_cnt + fail_cnt != base) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
      if (spam) start = busy ? 1'($urandom % 2) : 1'b0;
    end
    start = 1'b0;
    if (!finished) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done_or_fail required=done_or_fail", name);
    end
    repeat (12) @(negedge clk);
    chk({name, "_events_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_outcomes"}, 32'(done_cnt + fail_cnt - base), 32'd1);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    if (exp_end > 0) chk({name, "_end_cycle"}, 32'(last_ev_cyc - t0), 32'(exp_end));
  endtask

  initial begin
    int w0;
    bit reached;
    fill_mem(1'b0);
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cfg_gd = 0; cfg_rl = 1; cfg_err = -1; cfg_drop = -1;
    run("zero_wait", 65, 1'b0);

    cfg_gd = 3;
    run("gnt_delay3", 161, 1'b0);

    cfg_gd = 0; cfg_err = 7;
    w0 = wr_cnt;
    run("err_word7", 0, 1'b0);
    chk("err_word7_writes", 32'(wr_cnt - w0), 32'd6);
    cfg_err = -1;

    cfg_drop = 1;
    w0 = wr_cnt;
    run("timeout", 6, 1'b0);
    chk("timeout_no_write", 32'(wr_cnt - w0), 32'd0);
    cfg_drop = -1;

    // Reset while word 10 is in flight, then restart from x1.
    build_expect();
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (wr_cnt - w0 >= 9) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midreset_reached_word10", 32'(reached), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    exp_q.delete();
    chk("midreset_writes", 32'(wr_cnt - w0), 32'd9);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("restart", 65, 1'b0);

    w0 = wr_cnt;
    run("start_spam", 65, 1'b1);
    chk("start_spam_writes", 32'(wr_cnt - w0), 32'd31);

    cfg_err = 32;
    run("err_pc", 0, 1'b0);
    cfg_err = -1;

    for (int r = 0; r < 6; r++) begin
      fill_mem(1'b1);
      cfg_gd  = -1;
      cfg_rl  = -1;
      cfg_err = (r % 2 == 1) ? int'($urandom_range(1, 32)) : -1;
      run("random", 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
